// File: rtl/bcd_converter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_converter_if
//  Brief    : Input/output valid-ready bundle for the binary-to-BCD converter.
//  Revision : 1.0 - initial release
// ============================================================================
interface bcd_converter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, overflow, blank
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, overflow, blank
    );
endinterface
`default_nettype wire

// File: rtl/bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_converter
//  Brief    : Sequential shift-add-3 binary-to-BCD converter, one bit/cycle.
//             Optional leading-zero blanking: define BCD_LZ_BLANK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en,
    bcd_converter_if.slave  bus
);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_work;
    logic                 r_ovf_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_overflow;
    logic                 r_out_valid;

    logic [c_BCD_W-1:0]   w_adj;
    logic [c_BCD_W-1:0]   w_next_work;
    logic [WIDTH-1:0]     w_next_shift;
    logic                 w_carry;
    logic                 w_ovf_next;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        assign w_adj[4*k +: 4] = (r_work[4*k +: 4] >= 4'd5) ? r_work[4*k +: 4] + 4'd3
                                                              : r_work[4*k +: 4];
    end

    // Working register and input register shift as one chain; top bit feeds overflow.
    assign w_next_work  = {w_adj[c_BCD_W-2:0], r_shift[WIDTH-1]};
    assign w_next_shift = r_shift << 1;
    assign w_carry      = w_adj[c_BCD_W-1];
    assign w_ovf_next   = r_ovf_acc | w_carry;

`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0]    w_blank;
    logic                 w_above_zero;
    logic [DIGITS-1:0]    r_blank;

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        w_blank      = '0;
        w_above_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_above_zero = w_above_zero & (w_next_work[4*k +: 4] == 4'd0);
            w_blank[k]   = w_above_zero;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_work      <= '0;
            r_ovf_acc   <= 1'b0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
            r_blank     <= '0;
`endif
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_state   <= S_SHIFT;
                        r_shift   <= bus.bin;
                        r_work    <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= c_CNT_W'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    r_work    <= w_next_work;
                    r_shift   <= w_next_shift;
                    r_ovf_acc <= w_ovf_next;
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_bcd       <= w_next_work;
                        r_overflow  <= w_ovf_next;
                        r_out_valid <= 1'b1;
`ifdef BCD_LZ_BLANK_EN
                        r_blank     <= w_blank;
`endif
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = en & ~rst & (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.bcd       = r_bcd;
    assign bus.overflow  = r_overflow;
`ifdef BCD_LZ_BLANK_EN
    assign bus.blank     = r_blank;
`else
    assign bus.blank     = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_converter
//  Brief    : Self-checking bench for bcd_converter in three configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if0 ();
    bcd_converter_if #(.WIDTH(8), .DIGITS(2)) if1 ();
    bcd_converter_if #(.WIDTH(5), .DIGITS(2)) if2 ();

    bcd_converter #(.WIDTH(8), .DIGITS(3)) u_dut0 (.clk(clk), .rst(rst), .en(en), .bus(if0.slave));
    bcd_converter #(.WIDTH(8), .DIGITS(2)) u_dut1 (.clk(clk), .rst(rst), .en(en), .bus(if1.slave));
    bcd_converter #(.WIDTH(5), .DIGITS(2)) u_dut2 (.clk(clk), .rst(rst), .en(en), .bus(if2.slave));

    logic [11:0] a_bcd   [3];
    logic        a_ovf   [3];
    logic        a_ov    [3];
    logic        a_ir    [3];
    logic [2:0]  a_blank [3];

    always_comb begin
        a_bcd[0]   = if0.bcd;          a_bcd[1]   = {4'd0, if1.bcd};   a_bcd[2]   = {4'd0, if2.bcd};
        a_ovf[0]   = if0.overflow;     a_ovf[1]   = if1.overflow;      a_ovf[2]   = if2.overflow;
        a_ov[0]    = if0.out_valid;    a_ov[1]    = if1.out_valid;     a_ov[2]    = if2.out_valid;
        a_ir[0]    = if0.in_ready;     a_ir[1]    = if1.in_ready;      a_ir[2]    = if2.in_ready;
        a_blank[0] = if0.blank;        a_blank[1] = {1'b0, if1.blank}; a_blank[2] = {1'b0, if2.blank};
    end

    int errors = 0;
    int checks = 0;

    function automatic int ndig(input int d);
        return (d == 0) ? 3 : 2;
    endfunction

    function automatic int nwid(input int d);
        return (d == 2) ? 5 : 8;
    endfunction

    // Reference: decimal digits of v mod 10^nd, overflow when v does not fit.
    function automatic void model(input int nd, input int v, output logic [11:0] b,
                                  output logic o, output logic [2:0] bl);
        int p;
        int r;
        int q;
        p = 1;
        for (int k = 0; k < nd; k++) p = p * 10;
        o  = (v >= p);
        r  = v % p;
        b  = '0;
        bl = '0;
        for (int k = 0; k < nd; k++) begin
            b[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef BCD_LZ_BLANK_EN
        for (int k = 1; k < nd; k++) begin
            q = 1;
            for (int j = 0; j < k; j++) q = q * 10;
            bl[k] = (((v % p) / q) == 0);
        end
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic v, input logic [7:0] b);
        case (d)
            0:       begin if0.in_valid = v; if0.bin = b;      end
            1:       begin if1.in_valid = v; if1.bin = b;      end
            default: begin if2.in_valid = v; if2.bin = b[4:0]; end
        endcase
    endtask

    task automatic set_ordy(input logic r);
        if0.out_ready = r;
        if1.out_ready = r;
        if2.out_ready = r;
    endtask

    // Called at posedge+1; returns at posedge+1 once out_valid is seen (or on timeout).
    task automatic run(input int d, input logic [7:0] v, output int lat);
        int guard;
        guard = 0;
        set_in(d, 1'b1, v);
        while (!a_ir[d] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", 32'(a_ir[d]), 32'd1);
        @(posedge clk); #1;
        set_in(d, 1'b0, 8'h00);
        lat = 0;
        while (!a_ov[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_model(input int d, input int v, input int lat, input string tag);
        logic [11:0] eb;
        logic        eo;
        logic [2:0]  ebl;
        model(ndig(d), v, eb, eo, ebl);
        check($sformatf("%s_valid", tag), 32'(a_ov[d]),    32'd1);
        check($sformatf("%s_bcd", tag),   32'(a_bcd[d]),   32'(eb));
        check($sformatf("%s_ovf", tag),   32'(a_ovf[d]),   32'(eo));
        check($sformatf("%s_blank", tag), 32'(a_blank[d]), 32'(ebl));
        check($sformatf("%s_lat", tag),   32'(lat),        32'(nwid(d)));
    endtask

    typedef struct {
        int          d;
        logic [7:0]  v;
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int c0;
        int v;
        logic [2:0] eblank;

        tbl[0] = '{0, 8'd255, 12'h255, 1'b0, 3'b000};
        tbl[1] = '{0, 8'd0,   12'h000, 1'b0, 3'b110};
        tbl[2] = '{0, 8'd7,   12'h007, 1'b0, 3'b110};
        tbl[3] = '{1, 8'd200, 12'h000, 1'b1, 3'b010};
        tbl[4] = '{1, 8'd123, 12'h023, 1'b1, 3'b000};
        tbl[5] = '{1, 8'd99,  12'h099, 1'b0, 3'b000};
        tbl[6] = '{2, 8'd31,  12'h031, 1'b0, 3'b000};
        tbl[7] = '{2, 8'd10,  12'h010, 1'b0, 3'b000};
        tbl[8] = '{2, 8'd0,   12'h000, 1'b0, 3'b010};
        tbl[9] = '{0, 8'd42,  12'h042, 1'b0, 3'b100};

        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 8'h00);
        set_ordy(1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst%0d_in_ready", d),  32'(a_ir[d]),    32'd0);
            check($sformatf("rst%0d_out_valid", d), 32'(a_ov[d]),    32'd0);
            check($sformatf("rst%0d_bcd", d),       32'(a_bcd[d]),   32'd0);
            check($sformatf("rst%0d_ovf", d),       32'(a_ovf[d]),   32'd0);
            check($sformatf("rst%0d_blank", d),     32'(a_blank[d]), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(a_ir[0]), 32'd1);
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run(tbl[i].d, tbl[i].v, lat);
`ifdef BCD_LZ_BLANK_EN
            eblank = tbl[i].blank;
`else
            eblank = 3'b000;
`endif
            check($sformatf("tbl%0d_bcd", i),   32'(a_bcd[tbl[i].d]),   32'(tbl[i].bcd));
            check($sformatf("tbl%0d_ovf", i),   32'(a_ovf[tbl[i].d]),   32'(tbl[i].ovf));
            check($sformatf("tbl%0d_blank", i), 32'(a_blank[tbl[i].d]), 32'(eblank));
            check($sformatf("tbl%0d_lat", i),   32'(lat),               32'(nwid(tbl[i].d)));
        end

        // Back-to-back 0 then 7 with out_ready high
        @(posedge clk); #1;
        c0 = cyc;
        run(0, 8'd0, lat);
        check_model(0, 0, lat, "b2b_a");
        run(0, 8'd7, lat);
        check_model(0, 7, lat, "b2b_b");
        check("b2b_within_20", 32'((cyc - c0) <= 20), 32'd1);

        // Full sweep of the 5-bit, 2-digit configuration
        for (int i = 0; i < 32; i++) begin
            run(2, 8'(i), lat);
            check_model(2, i, lat, $sformatf("sweep%0d", i));
        end

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 255));
            run(i % 2, 8'(v), lat);
            check_model(i % 2, v, lat, $sformatf("rnd%0d", i));
        end

        // Backpressure: result holds, new requests ignored
        set_ordy(1'b0);
        run(0, 8'd153, lat);
        check_model(0, 153, lat, "bp");
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1'b1, 8'd7);
            @(posedge clk); #1;
            check($sformatf("bp%0d_bcd", i),      32'(a_bcd[0]), 32'h153);
            check($sformatf("bp%0d_valid", i),    32'(a_ov[0]),  32'd1);
            check($sformatf("bp%0d_in_ready", i), 32'(a_ir[0]),  32'd0);
        end
        set_in(0, 1'b0, 8'h00);
        set_ordy(1'b1);
        @(posedge clk); #1;
        check("bp_release_valid", 32'(a_ov[0]),  32'd0);
        check("bp_release_hold",  32'(a_bcd[0]), 32'h153);
        check("bp_release_ready", 32'(a_ir[0]),  32'd1);

        // Enable low for 3 cycles mid-conversion
        set_in(0, 1'b1, 8'd42);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h00);
        repeat (3) begin @(posedge clk); #1; end
        en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("en_low_no_valid", 32'(a_ov[0]), 32'd0);
        en = 1'b1;
        lat = 6;
        while (!a_ov[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("en_bcd", 32'(a_bcd[0]), 32'h042);
        check("en_lat", 32'(lat),      32'd11);
        @(posedge clk); #1;

        // Reset mid-conversion, then a clean conversion
        set_in(0, 1'b1, 8'd180);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h00);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready_held", 32'(a_ir[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_valid",    32'(a_ov[0]),  32'd0);
        check("midrst_bcd",      32'(a_bcd[0]), 32'd0);
        check("midrst_ovf",      32'(a_ovf[0]), 32'd0);
        check("midrst_in_ready", 32'(a_ir[0]),  32'(en));
        @(posedge clk); #1;
        run(0, 8'd180, lat);
        check_model(0, 180, lat, "after_rst");
        check("after_rst_bcd", 32'(a_bcd[0]), 32'h180);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bcd_converter.md
# bcd_converter

Parametrised sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per cycle. It converts a WIDTH-bit unsigned value into DIGITS packed BCD digits with a valid/ready handshake on both sides. It sits between the traffic-controller countdown counters and the 7-segment decoders, and serves wider counters and multi-digit displays from one block.

## Interface

- WIDTH, default 8: binary input width, minimum 1.
- DIGITS, default 3: number of BCD output digits, minimum 1.
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, synchronous and active-high. This is fixed: one clock only, synchronous active-high reset.
- en, input, 1: global enable. While low, the FSM, counters and registers hold, and no handshake completes.
- in_valid, input, 1: bin holds a value to convert.
- in_ready, output, 1: block accepts input. Equals en & (state==IDLE).
- bin, input, WIDTH: unsigned binary input, sampled only on the accept edge.
- out_valid, output, 1: bcd, overflow and blank are valid.
- out_ready, input, 1: consumer accepts the result.
- bcd, output, 4*DIGITS: packed BCD. Digit k (units is k=0) is at bits [4k+3:4k].
- overflow, output, 1: the input exceeded 10^DIGITS−1. bcd then holds bin mod 10^DIGITS.
- blank, output, DIGITS: leading-zero mask, one bit per digit (see Configuration).

## Operation

- States are IDLE, SHIFT and DONE.
- IDLE to SHIFT on an edge with en & in_valid & in_ready. On that edge:
  - the input shift register loads bin;
  - the BCD working register clears to 0;
  - the overflow accumulator clears;
  - the step counter loads WIDTH.
- SHIFT performs one step per edge with en=1:
  - Add 3 to every working digit that is ≥5.
  - Shift the working register and input register left by 1 as one chain. The input MSB enters the digit 0 LSB.
  - The bit leaving the top digit MSB is ORed into the overflow accumulator.
  - Decrement the counter.
- SHIFT to DONE on the step where the counter reaches 1 (the WIDTH-th step).
- On that same edge, bcd, overflow and blank registers are loaded and out_valid is set.
- DONE to IDLE on an edge with en & out_valid & out_ready. out_valid clears.
- bcd, overflow and blank keep their last values until the next DONE entry.
- Outputs are stable while out_valid=1. A consumer may stall indefinitely.
- Working-register width is 4*DIGITS. Add-3 is per digit in 4-bit arithmetic; a digit ≥5 after adjustment never exceeds 12 before the shift.
- WIDTH=1: SHIFT lasts a single step.
- Reset in any state forces IDLE and clears all outputs and internal registers.
- en low during SHIFT freezes the step. Conversion resumes with no lost or repeated steps.

## Timing

- Reset values: in_ready=0 while rst=1, then en-dependent. out_valid=0, bcd=0, overflow=0, blank=0.
- Latency: out_valid rises exactly WIDTH enabled edges after the accept edge. With en held high that is WIDTH cycles (8 for the defaults).
- Throughput: one conversion per WIDTH+2 cycles with out_ready held high. The cycles are accept, WIDTH shifts, and the DONE handshake.
- in_ready is low in SHIFT and DONE. in_valid asserted there is ignored, with no queuing.
- in_valid may drop before acceptance without effect. bin need only be stable on the accept edge.
- out_ready is ignored unless out_valid=1.
- No combinational path from in_valid or out_ready to any output. in_ready depends only on state and en.

## Configuration

- Macro BCD_LZ_BLANK_EN.
- Defined: blank[k]=1 when digit k and every digit above it are 0, for k≥1. blank[0] is always 0, so a zero value shows one "0". blank is registered on DONE entry together with bcd.
- Undefined: blank is tied to all zeros. No blanking logic is synthesised and the port remains for interface stability.

## Test plan

- Defaults, bin=8'd255: out_valid after 8 cycles, bcd=12'h255, overflow=0. With macro, blank=3'b000.
- Defaults, bin=0 then bin=7 back-to-back with out_ready=1: bcd=12'h000 then 12'h007. With macro, blank=3'b110 for both. Two results in 20 cycles.
- WIDTH=8, DIGITS=2:
  - bin=200: bcd=8'h00, overflow=1.
  - bin=123: bcd=8'h23, overflow=1.
  - bin=99: bcd=8'h99, overflow=0.
- WIDTH=5, DIGITS=2, sweep 0..31:
  - each bcd equals the decimal value, for example 31 gives 8'h31 and 10 gives 8'h10;
  - each latency is exactly 5 cycles;
  - overflow is always 0.
- Backpressure and enable: hold out_ready=0 for 10 cycles. bcd stays stable, in_ready=0 and a new in_valid is ignored. Toggle en low for 3 cycles mid-SHIFT on bin=8'd42: result is 12'h042 and latency is 8+3 cycles.
- Reset mid-conversion: assert rst at step 4 of bin=8'd180. The next cycle shows IDLE, out_valid=0, bcd=0 and in_ready=en. A subsequent conversion of bin=8'd180 gives 12'h180.
